frame_link_arbiter: RTL

Frame-link scheduler that shares the single 8-bit frame link feeding frame_decoder between two requesters, emitting one word per clock.
Serializes each granted request as header, address, 0..15 data words, trailer, using the same framing the decoder checks.
Round-robin arbitration between requesters; a link-enable input gates new grants.
Sits directly upstream of frame_decoder; word_out drives the decoder's word_in.

---
 rtl/frame_link_arbiter_if.sv | 35 +++
 rtl/frame_link_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/frame_link_arbiter_if.sv
// Bundle of the two requester ports and the outgoing frame link.
// No latency of its own; pure signal grouping.
// Backpressure: none on the link; requesters are paced by ack/done.
interface frame_link_arbiter_if #(
    parameter int LEN_W = 4
);
    logic             link_en;
    logic             req0;
    logic [7:0]       addr0;
    logic [LEN_W-1:0] len0;
    logic [7:0]       data0;
    logic             ack0;
    logic             done0;
    logic             req1;
    logic [7:0]       addr1;
    logic [LEN_W-1:0] len1;
    logic [7:0]       data1;
    logic             ack1;
    logic             done1;
    logic [7:0]       word_out;
    logic             word_valid;
    logic [1:0]       grant;

    // Requester/link side: drives requests, observes the framed link.
    modport master (
        output link_en, req0, addr0, len0, data0, req1, addr1, len1, data1,
        input  ack0, done0, ack1, done1, word_out, word_valid, grant
    );

    // Arbiter side.
    modport slave (
        input  link_en, req0, addr0, len0, data0, req1, addr1, len1, data1,
        output ack0, done0, ack1, done1, word_out, word_valid, grant
    );
endinterface

// File: rtl/frame_link_arbiter.sv
// Round-robin scheduler framing two requesters onto one 8-bit link (HDR, addr, data*, TRL).
// Latency: HDR appears 1 clock after a grant decision; a frame with N data words is N+3 words.
// Backpressure: none on the link; link_en only gates new grants, ack paces requester data.
module frame_link_arbiter #(
    parameter logic [7:0] HDR   = 8'hC9,
    parameter logic [7:0] TRL   = 8'h9C,
    parameter int         LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    frame_link_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_ADDR = 2'd1,
        SEND_DATA = 2'd2,
        SEND_TRL  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       word_q, word_d;
    logic             vld_q, vld_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       done_q, done_d;
    logic             last_q, last_d;
    logic [1:0]       ack_c;
    logic             win;

    // Winner pick: a lone requester wins outright; on contention the one that lost last time wins.
    always_comb begin
        win = ~last_q;
        if (bus.req0 && !bus.req1) begin
            win = 1'b0;
        end else if (!bus.req0 && bus.req1) begin
            win = 1'b1;
        end
    end

    // Next-state and next-output logic; the current owner is carried in grant_q[1].
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        word_d  = word_q;
        vld_d   = vld_q;
        grant_d = grant_q;
        done_d  = 2'b00;
        last_d  = last_q;
        ack_c   = 2'b00;
        case (state_q)
            IDLE: begin
                if (bus.link_en && (bus.req0 || bus.req1)) begin
                    grant_d = win ? 2'b10 : 2'b01;
                    addr_d  = win ? bus.addr1 : bus.addr0;
                    len_d   = win ? bus.len1 : bus.len0;
                    word_d  = HDR;
                    vld_d   = 1'b1;
                    last_d  = win;
                    state_d = SEND_ADDR;
                end else begin
                    word_d  = 8'h00;
                    vld_d   = 1'b0;
                    grant_d = 2'b00;
                end
            end
            SEND_ADDR: begin
                word_d  = addr_q;
                vld_d   = 1'b1;
                cnt_d   = len_q;
                state_d = (len_q != '0) ? SEND_DATA : SEND_TRL;
            end
            SEND_DATA: begin
                ack_c   = grant_q;
                word_d  = grant_q[1] ? bus.data1 : bus.data0;
                vld_d   = 1'b1;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = SEND_TRL;
                end
            end
            SEND_TRL: begin
                word_d  = TRL;
                vld_d   = 1'b1;
                done_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything at once, truncating any frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= 8'h00;
            word_q  <= 8'h00;
            vld_q   <= 1'b0;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            vld_q   <= vld_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign bus.ack0       = ack_c[0];
    assign bus.ack1       = ack_c[1];
    assign bus.done0      = done_q[0];
    assign bus.done1      = done_q[1];
    assign bus.word_out   = word_q;
    assign bus.word_valid = vld_q;
    assign bus.grant      = grant_q;

endmodule
